// File: rtl/wtm_pkg.sv
// Shared sizing helpers for the Wallace-tree multiplier: reduction depth, per-level
// row counts and the Baugh-Wooley correction constant. Pure functions, no state.
package wtm_pkg;

  function automatic int wtm_rows(input int w, input int lvl);
    int n;
    n = w;
    for (int i = 0; i < lvl; i++) n = n - n / 3;
    return n;
  endfunction

  function automatic int wtm_levels(input int w);
    int n;
    int l;
    n = w;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = n - n / 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Signed-mode constant: ones at bit w and bit 2w-1 of the 2w-bit product.
  function automatic logic [63:0] wtm_bw_const(input int w);
    return (64'd1 << w) | (64'd1 << (2 * w - 1));
  endfunction

endpackage

// File: rtl/cla_adder.sv
// N-bit carry-lookahead adder built from 4-bit lookahead blocks; combinational.
// Sum is modulo 2^N; no carry-in, carry-out is discarded.
module cla_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  localparam int NB = (N + 3) / 4;
  localparam int NP = 4 * NB;

  logic [NP-1:0] a, b, g, p, c, s;
  logic [NB-1:0] bcin, bcout;
  logic          unused_cout;

  assign a = NP'(a_i);
  assign b = NP'(b_i);
  assign g = a & b;
  assign p = a ^ b;
  assign bcin[0] = 1'b0;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [3:0] gk, pk;
    logic       cin;
    assign gk = g[4*k +: 4];
    assign pk = p[4*k +: 4];
    assign cin = bcin[k];
    assign c[4*k]   = cin;
    assign c[4*k+1] = gk[0] | (pk[0] & cin);
    assign c[4*k+2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & cin);
    assign c[4*k+3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0]) | (pk[2] & pk[1] & pk[0] & cin);
    assign bcout[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                    | (pk[3] & pk[2] & pk[1] & gk[0]) | ((&pk) & cin);
    if (k < NB - 1) begin : g_chain
      assign bcin[k+1] = bcout[k];
    end
  end

  assign s = p ^ c;
  assign sum_o = s[N-1:0];

  if (NP > N) begin : g_pad
    assign unused_cout = bcout[NB-1] ^ (^s[NP-1:N]);
  end else begin : g_nopad
    assign unused_cout = bcout[NB-1];
  end

endmodule

// File: rtl/csa_row.sv
// 3:2 carry-save compressor over N bits; combinational, no handshake.
// Carry is pre-shifted into its weight; the bit shifted out of the top is dropped (mod 2^N).
module csa_row #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);

  logic [N-1:0] maj;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = {maj[N-2:0], 1'b0};

endmodule

// File: rtl/wtm_mul_pipe.sv
// Pipelined WxW Wallace-tree multiplier (unsigned or Baugh-Wooley signed), latency LEVELS+1.
// Global stall: every stage holds while out_valid && !out_ready; in_ready = !stall.
module wtm_mul_pipe
  import wtm_pkg::*;
#(
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_product,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW     = 2 * W;
  localparam int LEVELS = wtm_levels(W);
  localparam logic [PW-1:0] BW_CONST  = PW'(wtm_bw_const(W));
  localparam logic [PW-1:0] LAST_MASK = PW'({(W-1){1'b1}}) << (W - 1);

  logic             advance;
  logic [LEVELS:0]  vld_q;
  logic [TAG_W-1:0] tag_q [LEVELS+1];
  logic [W-1:0]     a_q, b_q;
  logic             sgn_q;
  logic [PW-1:0]    pp [W];
  logic [PW-1:0]    prod_d;
  logic             out_valid_q;
  logic [PW-1:0]    out_product_q;
  logic [TAG_W-1:0] out_tag_q;

  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;

  // Partial products are formed from the registered operands so in_signed only lives in stage 0.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      pp[i] = PW'(a_q & {W{b_q[i]}}) << i;
      if (sgn_q) begin
        if (i < W - 1) pp[i][W-1+i] = ~pp[i][W-1+i];
        else           pp[i] = pp[i] ^ LAST_MASK;
      end
    end
    if (sgn_q) pp[0] = pp[0] | BW_CONST;
  end

  for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_lvl
    localparam int N = wtm_rows(W, lvl);
    localparam int G = N / 3;
    localparam int M = N - G;

    logic [PW-1:0] src    [N];
    logic [PW-1:0] s      [G];
    logic [PW-1:0] cy     [G];
    logic [PW-1:0] rows_d [M];
    logic [PW-1:0] rows_q [M];

    if (lvl == 0) begin : g_src_pp
      assign src = pp;
    end else begin : g_src_prev
      assign src = g_lvl[lvl-1].rows_q;
    end

    for (genvar j = 0; j < G; j++) begin : g_grp
      csa_row #(.N(PW)) u_csa (
        .a_i    (src[3*j]),
        .b_i    (src[3*j+1]),
        .c_i    (src[3*j+2]),
        .sum_o  (s[j]),
        .carry_o(cy[j])
      );
      assign rows_d[2*j]   = s[j];
      assign rows_d[2*j+1] = cy[j];
    end

    for (genvar r = 0; r < M - 2 * G; r++) begin : g_pass
      assign rows_d[2*G+r] = src[3*G+r];
    end

    always_ff @(posedge clk) begin
      if (advance) rows_q <= rows_d;
    end
  end

  cla_adder #(.N(PW)) u_cpa (
    .a_i  (g_lvl[LEVELS-1].rows_q[0]),
    .b_i  (g_lvl[LEVELS-1].rows_q[1]),
    .sum_o(prod_d)
  );

  always_ff @(posedge clk) begin
    if (advance) begin
      a_q      <= in_a;
      b_q      <= in_b;
      sgn_q    <= in_signed;
      tag_q[0] <= in_tag;
      for (int st = 1; st <= LEVELS; st++) tag_q[st] <= tag_q[st-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_tag_q     <= '0;
    end else if (advance) begin
      vld_q         <= {vld_q[LEVELS-1:0], in_valid};
      out_valid_q   <= vld_q[LEVELS];
      out_product_q <= prod_d;
      out_tag_q     <= tag_q[LEVELS];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_wtm_mul_pipe.sv
// Bench for wtm_mul_pipe at W = 16, 8, 4 and 32: directed vectors with latency,
// random/exhaustive streams under backpressure, and a mid-stream reset.
module tb_wtm_mul_pipe;

  typedef struct {
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    bit          sgn;
    logic [3:0]  tag;
    logic [63:0] exp;
  } vec_t;

  localparam int NVEC = 11;

  logic clk;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  vec_t vecs [NVEC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    vecs[0]  = '{16, 64'hFFFF,     64'hFFFF,     1'b0, 4'h3, 64'hFFFE0001};
    vecs[1]  = '{16, 64'hFFFF,     64'hFFFF,     1'b1, 4'h5, 64'h00000001};
    vecs[2]  = '{16, 64'h8000,     64'h8000,     1'b1, 4'h6, 64'h40000000};
    vecs[3]  = '{16, 64'h8000,     64'h7FFF,     1'b1, 4'h7, 64'hC0008000};
    vecs[4]  = '{16, 64'h0000,     64'h1234,     1'b1, 4'h8, 64'h0};
    vecs[5]  = '{8,  64'h80,       64'h80,       1'b1, 4'h9, 64'h4000};
    vecs[6]  = '{8,  64'h7F,       64'hFF,       1'b1, 4'hA, 64'hFF81};
    vecs[7]  = '{4,  64'h8,        64'h8,        1'b1, 4'hB, 64'h40};
    vecs[8]  = '{4,  64'hF,        64'hF,        1'b0, 4'hC, 64'hE1};
    vecs[9]  = '{32, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 4'hD, 64'hFFFFFFFE00000001};
    vecs[10] = '{32, 64'h80000000, 64'h7FFFFFFF, 1'b1, 4'hE, 64'hC000000080000000};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input bit sgn);
    longint sa, sb;
    logic [63:0] mask;
    if (sgn) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    mask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(sa * sb) & mask;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int WK   = (k == 0) ? 16 : (k == 1) ? 8 : (k == 2) ? 4 : 32;
    localparam int LAT  = (k == 0) ? 7 : (k == 1) ? 5 : (k == 2) ? 3 : 9;
    localparam int NOPS = (k == 0) ? 200 : (k == 1) ? 200 : (k == 2) ? 512 : 10000;

    logic          rst, in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [WK-1:0] in_a, in_b;
    logic [3:0]    in_tag, out_tag;
    logic [2*WK-1:0] out_product;
    logic [67:0]   sb_q [$];

    wtm_mul_pipe #(.W(WK), .TAG_W(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_signed  (in_signed),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_product(out_product),
      .out_tag    (out_tag)
    );

    // Scoreboard and stall monitor: all handshakes are judged at the falling edge.
    initial begin
      logic            stalled;
      logic [2*WK-1:0] held_p;
      logic [3:0]      held_t;
      logic [67:0]     e;
      stalled = 1'b0;
      held_p  = '0;
      held_t  = '0;
      forever begin
        @(negedge clk);
        if (stalled) begin
          check($sformatf("w%0d_stall_product", WK), 64'(out_product), 64'(held_p));
          check($sformatf("w%0d_stall_tag", WK), 64'(out_tag), 64'(held_t));
        end
        stalled = (rst === 1'b0) && (out_valid === 1'b1) && (out_ready === 1'b0);
        held_p  = out_product;
        held_t  = out_tag;
        if (rst !== 1'b0) begin
          sb_q.delete();
        end else begin
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check($sformatf("w%0d_output_expected", WK), 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              check($sformatf("w%0d_product", WK), 64'(out_product), e[63:0]);
              check($sformatf("w%0d_tag_order", WK), 64'(out_tag), 64'(e[67:64]));
            end
          end
          if (in_valid === 1'b1 && in_ready === 1'b1)
            sb_q.push_back({in_tag, ref_mul(WK, 64'(in_a), 64'(in_b), in_signed)});
        end
      end
    end

    task automatic run_one(input logic [WK-1:0] a, input logic [WK-1:0] b, input bit sgn,
                           input logic [3:0] tag, input logic [63:0] exp);
      int lat;
      bit got;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (LAT + 2) @(posedge clk);
      #1;
      in_a = a; in_b = b; in_signed = sgn; in_tag = tag; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
        got = (out_valid === 1'b1);
      end
      check($sformatf("w%0d_latency_tag%0h", WK, tag), 64'(lat), 64'(LAT));
      check($sformatf("w%0d_vec_product_tag%0h", WK, tag), 64'(out_product), exp);
      check($sformatf("w%0d_vec_tag_tag%0h", WK, tag), 64'(out_tag), 64'(tag));
    endtask

    initial begin
      bit          acc;
      int          tries;
      logic [WK-1:0] a, b;
      bit          sgn;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("w%0d_in_ready_in_reset", WK), 64'(in_ready), 64'd1);
      rst = 1'b0;
      check($sformatf("w%0d_reset_out_valid", WK), 64'(out_valid), 64'd0);
      check($sformatf("w%0d_reset_product", WK), 64'(out_product), 64'd0);
      check($sformatf("w%0d_reset_tag", WK), 64'(out_tag), 64'd0);

      for (int v = 0; v < NVEC; v++)
        if (vecs[v].w == WK)
          run_one(WK'(vecs[v].a), WK'(vecs[v].b), vecs[v].sgn, vecs[v].tag, vecs[v].exp);

      for (int i = 0; i < NOPS; i++) begin
        if (WK == 4) begin
          a = WK'(i >> 4); b = WK'(i); sgn = i[8];
        end else begin
          a = WK'($urandom); b = WK'($urandom); sgn = 1'($urandom_range(0, 1));
        end
        in_a = a; in_b = b; in_signed = sgn; in_tag = 4'(i); in_valid = 1'b1;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
          out_ready = (k == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
          @(negedge clk);
          acc = (in_ready === 1'b1);
          @(posedge clk);
          #1;
          tries++;
        end
        if (!acc) check($sformatf("w%0d_accept_op%0d", WK, i), 64'(acc), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 60 && sb_q.size() > 0; t++) @(posedge clk);
      #1;
      check($sformatf("w%0d_stream_drained", WK), 64'(sb_q.size()), 64'd0);

      for (int i = 0; i < 5; i++) begin
        in_a = WK'($urandom); in_b = WK'($urandom);
        in_signed = 1'($urandom_range(0, 1)); in_tag = 4'(i + 1); in_valid = 1'b1;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check($sformatf("w%0d_out_valid_after_rst", WK), 64'(out_valid), 64'd0);
      a = WK'($urandom); b = WK'($urandom);
      run_one(a, b, 1'b1, 4'hF, ref_mul(WK, 64'(a), 64'(b), 1'b1));
      repeat (LAT + 2) @(posedge clk);
      #1;
      check($sformatf("w%0d_final_drained", WK), 64'(sb_q.size()), 64'd0);
      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && done_cnt < 4; t++) @(posedge clk);
    #2;
    check("all_widths_done", 64'(done_cnt), 64'd4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
